// File: rtl/riscv_dbg_byte_bridge.sv
// Host byte-stream front end of the per-hart Debug Unit: decodes CMD/ADDR/DATA frames
// into single debug-bus transactions and streams back status, read data and breakpoint events.
module riscv_dbg_byte_bridge #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            rx_valid,
   input  logic [7:0]      rx_data,
   output logic            rx_ready,
   output logic            tx_valid,
   output logic [7:0]      tx_data,
   input  logic            tx_ready,
   output logic            dbg_strb,
   output logic            dbg_we,
   output logic [15:0]     dbg_addr,
   output logic [XLEN-1:0] dbg_dati,
   input  logic [XLEN-1:0] dbg_dato,
   input  logic            dbg_ack,
   input  logic            dbg_bp
);

   localparam int NB = XLEN / 8;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

   typedef enum logic [2:0] {
      S_CMD, S_EVT, S_ADDR_HI, S_ADDR_LO, S_DATA, S_BUS, S_RESP_STAT, S_RESP_DATA
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_we;
   logic [15:0]     r_addr;
   logic [XLEN-1:0] r_dati;
   logic [XLEN-1:0] r_rdata;
   logic [7:0]      r_status;
   logic [IW-1:0]   r_idx;
   logic [CW-1:0]   r_cnt;
   logic            r_bp_prev;
   logic            r_bp_pending;

   logic w_rx_fire;
   logic w_tx_fire;
   logic w_bad_cmd;
   logic w_bus_done;
   logic w_bp_rise;

   assign w_rx_fire  = rx_valid & rx_ready;
   assign w_tx_fire  = tx_valid & tx_ready;
   assign w_bad_cmd  = |rx_data[6:0];
   assign w_bus_done = dbg_ack | (r_cnt == TO_LAST);
   assign w_bp_rise  = dbg_bp & ~r_bp_prev;

   // Strobe decodes straight from the state so an asynchronous reset drops it at once.
   assign dbg_strb = (r_state == S_BUS);
   assign dbg_we   = r_we;
   assign dbg_addr = r_addr;
   assign dbg_dati = r_dati;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_CMD;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (r_state)
         S_CMD: begin
            rx_ready = rstn & ~r_bp_pending;
            if (r_bp_pending)  w_next = S_EVT;
            else if (rx_valid) w_next = w_bad_cmd ? S_RESP_STAT : S_ADDR_HI;
         end
         S_EVT: begin
            tx_valid = 1'b1;
            tx_data  = 8'h80;
            if (tx_ready) w_next = S_CMD;
         end
         S_ADDR_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) w_next = S_ADDR_LO;
         end
         S_ADDR_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) w_next = r_we ? S_DATA : S_BUS;
         end
         S_DATA: begin
            rx_ready = 1'b1;
            if (rx_valid && r_idx == IDX_LAST) w_next = S_BUS;
         end
         S_BUS: begin
            if (w_bus_done) w_next = S_RESP_STAT;
         end
         S_RESP_STAT: begin
            tx_valid = 1'b1;
            tx_data  = r_status;
            if (tx_ready) w_next = (!r_we && r_status == 8'h00) ? S_RESP_DATA : S_CMD;
         end
         S_RESP_DATA: begin
            tx_valid = 1'b1;
            tx_data  = r_rdata[XLEN-1 -: 8];
            if (tx_ready && r_idx == IDX_LAST) w_next = S_CMD;
         end
         default: w_next = S_CMD;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_dati       <= '0;
         r_rdata      <= '0;
         r_status     <= 8'h00;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_bp_prev    <= 1'b0;
         r_bp_pending <= 1'b0;
      end else begin
         r_bp_prev <= dbg_bp;
         // A fresh edge in the same cycle the event is sent stays pending for the next one.
         if (w_bp_rise)                          r_bp_pending <= 1'b1;
         else if (r_state == S_EVT && tx_ready) r_bp_pending <= 1'b0;

         case (r_state)
            S_CMD: begin
               r_idx <= '0;
               r_cnt <= '0;
               if (w_rx_fire) begin
                  if (w_bad_cmd) r_status <= 8'h02;
                  else           r_we     <= rx_data[7];
               end
            end
            S_ADDR_HI: if (w_rx_fire) r_addr[15:8] <= rx_data;
            S_ADDR_LO: begin
               r_idx <= '0;
               if (w_rx_fire) r_addr[7:0] <= rx_data;
            end
            S_DATA: begin
               if (w_rx_fire) begin
                  r_dati <= {r_dati[XLEN-9:0], rx_data};
                  r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
               end
            end
            S_BUS: begin
               if (dbg_ack) begin
                  r_rdata  <= dbg_dato;
                  r_status <= 8'h00;
                  r_cnt    <= '0;
               end else if (r_cnt == TO_LAST) begin
                  r_status <= 8'h01;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP_STAT: r_idx <= '0;
            S_RESP_DATA: begin
               if (w_tx_fire) begin
                  r_rdata <= {r_rdata[XLEN-9:0], 8'h00};
                  r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
